// File: rtl/bcd_score_timer_if.sv
// Control and display bundle between the game-control FSM and bcd_score_timer.
// Master: game controller (drives strobes/levels). Slave: the score timer.
interface bcd_score_timer_if #(
    parameter int DIGITS = 4
);
    logic                  gameOver;
    logic                  pause;
    logic                  restart;
    logic                  bonus;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [7*DIGITS-1:0]   hex;
    logic                  saturated;
    logic [4*DIGITS-1:0]   best_bcd;
    logic                  new_best;

    modport master (
        output gameOver, pause, restart, bonus,
        input  score_bcd, hex, saturated, best_bcd, new_best
    );

    modport slave (
        input  gameOver, pause, restart, bonus,
        output score_bcd, hex, saturated, best_bcd, new_best
    );
endinterface

// File: rtl/bcd_score_timer.sv
// BCD game score timer: divided tick counting, bonus addition, saturation, 7-seg decode.
// Optional best-score latch enabled by defining BCD_SCORE_BEST_EN.
module bcd_score_timer #(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 50000000,
    parameter int BONUS_DIGIT = 1
) (
    input  logic               clkin,
    input  logic               reset,
    bcd_score_timer_if.slave   bus
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int SW    = 4 * DIGITS;
    localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SW-1:0]     score_q, score_d;
    logic              restart_ok_s;
    logic              count_en_s;
    logic              tick_s;
    logic              bonus_ok_s;
    logic [SW:0]       sum_s;
    logic [7*DIGITS-1:0] hex_s;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Adds tick (at digit 0) and bonus (at BONUS_DIGIT) with ripple carry; MSB is overflow.
    function automatic logic [SW:0] bcd_add(input logic [SW-1:0] a, input logic tk, input logic bn);
        logic [4:0]  t;
        logic        c;
        logic [SW:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, a[4*i +: 4]} + {4'b0000, c}
              + {4'b0000, tk && (i == 0)} + {4'b0000, bn && (i == BONUS_DIGIT)};
            if (t >= 5'd10) begin
                r[4*i +: 4] = 4'(t - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = t[3:0];
                c = 1'b0;
            end
        end
        r[SW] = c;
        return r;
    endfunction

    assign restart_ok_s = bus.restart && !bus.gameOver;
    assign count_en_s   = (state_q == ST_RUN) && !bus.pause && !bus.gameOver;
    assign tick_s       = count_en_s && (div_q == DIV_W'(TICK_DIV - 1));
    assign bonus_ok_s   = bus.bonus && (state_q != ST_OVER);
    assign sum_s        = bcd_add(score_q, tick_s, bonus_ok_s);

    // Next state: a valid restart overrides everything; gameOver outranks pause.
    always_comb begin
        state_d = state_q;
        if (restart_ok_s) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  state_d = bus.gameOver ? ST_OVER : (bus.pause ? ST_HOLD : ST_RUN);
                ST_HOLD: state_d = bus.gameOver ? ST_OVER : (bus.pause ? ST_HOLD : ST_RUN);
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Divider and score next values; overflow clamps to all nines.
    always_comb begin
        div_d   = div_q;
        score_d = score_q;
        if (restart_ok_s) begin
            div_d   = '0;
            score_d = '0;
        end else begin
            if (tick_s) begin
                div_d = '0;
            end else if (count_en_s) begin
                div_d = div_q + DIV_W'(1);
            end else begin
                div_d = div_q;
            end
            if (sum_s[SW]) begin
                score_d = ALL_NINES;
            end else begin
                score_d = sum_s[SW-1:0];
            end
        end
    end

    // Core state registers.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            div_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            score_q <= score_d;
        end
    end

    // Per-digit seven-segment decode of the registered score.
    always_comb begin
        hex_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex_s[7*i +: 7] = seg7(score_q[4*i +: 4]);
        end
    end

    assign bus.score_bcd = score_q;
    assign bus.hex       = hex_s;
    assign bus.saturated = (score_q == ALL_NINES);

`ifdef BCD_SCORE_BEST_EN
    logic [SW-1:0] best_q, best_d;
    logic          new_best_q, new_best_d;

    // Latch the pre-update score on entry to OVER; valid BCD compares like binary.
    always_comb begin
        best_d     = best_q;
        new_best_d = 1'b0;
        if ((state_q != ST_OVER) && (state_d == ST_OVER) && (score_q > best_q)) begin
            best_d     = score_q;
            new_best_d = 1'b1;
        end else begin
            best_d     = best_q;
            new_best_d = 1'b0;
        end
    end

    // Best-score registers; only the async reset clears them.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            best_q     <= '0;
            new_best_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    assign bus.best_bcd = best_q;
    assign bus.new_best = new_best_q;
`else
    assign bus.best_bcd = '0;
    assign bus.new_best = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_score_timer.sv
// Randomized + directed bench for bcd_score_timer against an integer-arithmetic score model.
module tb_bcd_score_timer;
    localparam int DIGITS = 4;
    localparam int TD     = 4;
    localparam int BD     = 1;
    localparam int SW     = 4 * DIGITS;
    localparam int MAXV   = 9999;
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    logic clkin = 1'b0;
    logic reset = 1'b0;

    bcd_score_timer_if #(.DIGITS(DIGITS)) bus ();

    bcd_score_timer #(.DIGITS(DIGITS), .TICK_DIV(TD), .BONUS_DIGIT(BD)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;

    // Reference model: decimal score, elapsed-cycle phase, play mode flags.
    int m_score, m_div, m_best;
    bit m_over, m_hold, m_nb;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_hex(input int v);
        logic [7*DIGITS-1:0] h;
        int x;
        x = v;
        h = '0;
        for (int i = 0; i < DIGITS; i++) begin
            h[7*i +: 7] = SEG_TAB[x % 10];
            x = x / 10;
        end
        return h;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_div = 0; m_best = 0;
        m_over = 1'b0; m_hold = 1'b0; m_nb = 1'b0;
    endtask

    task automatic model_edge(input bit go, input bit p, input bit r, input bit b);
        int prev;
        int add;
        prev = m_score;
        add  = 0;
        m_nb = 1'b0;
        if (r && !go) begin
            m_score = 0; m_div = 0; m_over = 1'b0; m_hold = 1'b0;
        end else begin
            if (!m_over && !m_hold && !p && !go) begin
                m_div++;
                if (m_div == TD) begin
                    m_div = 0;
                    add   = 1;
                end
            end
            if (b && !m_over) add += 10 ** BD;
            if (add > 0) m_score = (prev + add > MAXV) ? MAXV : prev + add;
`ifdef BCD_SCORE_BEST_EN
            if (!m_over && go && prev > m_best) begin
                m_best = prev;
                m_nb   = 1'b1;
            end
`endif
            if (!m_over) begin
                if (go) begin
                    m_over = 1'b1;
                    m_hold = 1'b0;
                end else begin
                    m_hold = p;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("score", bus.score_bcd, to_bcd(m_score));
        check_val("hex",   bus.hex, exp_hex(m_score));
        check_val("sat",   bus.saturated, m_score == MAXV);
        check_val("best",  bus.best_bcd, to_bcd(m_best));
        check_val("nbest", bus.new_best, m_nb);
    endtask

    // Called just after a falling edge: drive, take one rising edge, check, return at next falling edge.
    task automatic step(input bit go, input bit p, input bit r, input bit b);
        bus.gameOver = go; bus.pause = p; bus.restart = r; bus.bonus = b;
        @(posedge clkin);
        model_edge(go, p, r, b);
        #1;
        compare_all();
        @(negedge clkin);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go_to(input int target);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        while (m_score + 10 ** BD <= target) step(1'b0, 1'b1, 1'b0, 1'b1);
        while (m_score < target) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int snap, snapdiv, n;

    initial begin
        bus.gameOver = 1'b0; bus.pause = 1'b0; bus.restart = 1'b0; bus.bonus = 1'b0;
        model_reset();
        #12;
        compare_all();
        check_val("rst_hex", bus.hex, {DIGITS{7'b1000000}});
        @(negedge clkin);
        reset = 1'b1;

        idle(40);
        check_val("t40_score", bus.score_bcd, 16'h0010);
        check_val("t40_hex1", bus.hex[13:7], 7'b1111001);
        check_val("t40_hex0", bus.hex[6:0], 7'b1000000);
        idle(4 * 89);
        check_val("s99", bus.score_bcd, 16'h0099);
        idle(4);
        check_val("s100", bus.score_bcd, 16'h0100);

        go_to(9);
        while (m_div != TD - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("tick_bonus", bus.score_bcd, 16'h0020);

        go_to(995);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("bonus_carry", bus.score_bcd, 16'h1005);

        go_to(9995);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
        check_val("sat_score", bus.score_bcd, 16'h9999);
        check_val("sat_flag", bus.saturated, 1'b1);
        idle(20);
        check_val("sat_hold", bus.score_bcd, 16'h9999);

        go_to(37);
        idle(2);
        snap = m_score;
        snapdiv = m_div;
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("pause_score", bus.score_bcd, to_bcd(snap));
        n = 0;
        while (bus.score_bcd == to_bcd(snap) && n < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("pause_div", n, 1 + TD - snapdiv);

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        snap = m_score;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("over_rst_ign", bus.score_bcd, to_bcd(snap));
        idle(5);
        check_val("over_frozen", bus.score_bcd, to_bcd(snap));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("restart_clr", bus.score_bcd, 16'h0000);
        idle(TD);
        check_val("restart_run", bus.score_bcd, 16'h0001);

        go_to(12);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef BCD_SCORE_BEST_EN
        check_val("best12", bus.best_bcd, 16'h0012);
        check_val("nb_pulse", bus.new_best, 1'b1);
`else
        check_val("best12", bus.best_bcd, 16'h0000);
        check_val("nb_pulse", bus.new_best, 1'b0);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("nb_end", bus.new_best, 1'b0);
        go_to(5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef BCD_SCORE_BEST_EN
        check_val("best_keep", bus.best_bcd, 16'h0012);
`else
        check_val("best_keep", bus.best_bcd, 16'h0000);
`endif
        check_val("nb_none", bus.new_best, 1'b0);

        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 30);
        end

        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_val("async_rst", bus.score_bcd, 16'h0000);
        @(negedge clkin);
        reset = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_score_timer.md
# bcd_score_timer

Parametrised game score timer: counts elapsed seconds (or any divided tick) as a DIGITS-wide packed BCD value, adds bonus points on request, and drives one seven-segment pattern per digit. It sits between the game-control FSM (gameOver, pause, restart, bonus strobes) and the board HEX displays. It succeeds the fixed 4-digit score counter with configurable width and tick rate, pause/restart control, bonus addition, an explicit saturation flag, and an optional best-score latch.

## Interface
- DIGITS, 4: number of BCD digits, 1–8.
- TICK_DIV, 50000000: clkin cycles per score increment, ≥ 2.
- BONUS_DIGIT, 1: digit index receiving a bonus increment (1 = tens, i.e. +10), 0..DIGITS-1.

- clkin  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- gameOver  in  1  level; high freezes score and enters OVER.
- pause  in  1  level; high freezes score and divider (RUN only).
- restart  in  1  single-cycle pulse; clears score and divider, returns to RUN.
- bonus  in  1  single-cycle pulse; adds 10^BONUS_DIGIT to score.
- score_bcd  out  4*DIGITS  packed BCD score, digit 0 in [3:0].
- hex  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit, digit 0 in [6:0].
- saturated  out  1  high while score is all 9s.
- best_bcd  out  4*DIGITS  best score (see Configuration).
- new_best  out  1  one-cycle pulse when best_bcd is updated.

## Operation
- States: RUN, HOLD, OVER. Reset enters RUN (counting begins immediately after reset release).
- RUN → OVER when gameOver=1 (priority over pause). RUN → HOLD when pause=1 and gameOver=0. HOLD → RUN when pause=0; HOLD → OVER when gameOver=1.
- OVER → RUN only on restart=1 with gameOver=0; restart while gameOver=1 is ignored.
- restart in any state (gameOver=0): score, divider cleared to 0 that cycle; tick and bonus in the same cycle are discarded.
- Divider: width $clog2(TICK_DIV), counts 0..TICK_DIV-1 in RUN only, frozen in HOLD/OVER; tick asserted when divider == TICK_DIV-1, divider wraps to 0.
- Tick adds 1 to digit 0 with BCD ripple carry through all digits.
- Bonus (RUN or HOLD only; ignored in OVER) adds 1 at BONUS_DIGIT with ripple carry upward.
- Tick and bonus same cycle: both applied (+1 and +10^BONUS_DIGIT) in one update.
- Saturation: any sum exceeding all-9s clamps to all-9s; no wrap. While saturated the divider keeps running but increments are dropped.
- hex is combinational decode of score_bcd: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.

## Timing
- Reset values: score_bcd=0, divider=0, state=RUN, saturated=0, best_bcd=0, new_best=0, hex=all digits 1000000.
- First tick increment visible on score_bcd after the TICK_DIV-th rising edge following reset release; thereafter one increment every TICK_DIV cycles in RUN.
- Bonus: score_bcd updates on the edge that samples bonus=1 (1-cycle latency).
- saturated, hex follow score_bcd combinationally in the same cycle.
- Reset mid-operation asynchronously clears everything, including best_bcd.

## Configuration
- BCD_SCORE_BEST_EN defined: on the RUN/HOLD → OVER transition edge, if score_bcd > best_bcd (BCD magnitude compare), best_bcd ← score_bcd and new_best pulses for exactly one cycle; best_bcd survives restart.
- Undefined: best_bcd tied to 0, new_best tied to 0, no compare logic instantiated.

## Test plan
- DIGITS=4, TICK_DIV=4: release reset, run 40 cycles → score_bcd=0x0010, hex[13:7]=1111001, hex[6:0]=1000000.
- Start at 0x0099 via ticks, one more tick → 0x0100; bonus at 0x0995 → 0x1005.
- Tick and bonus same cycle at 0x0009 → 0x0020.
- Drive to 0x9995, then 3 bonus pulses → 0x9999, saturated=1; further ticks leave 0x9999.
- pause=1 for 20 cycles → score and divider unchanged; gameOver=1 then restart with gameOver=1 → ignored; gameOver=0 + restart → score 0x0000, RUN.
- With BCD_SCORE_BEST_EN: game to 0x0012, gameOver → best_bcd=0x0012, new_best one cycle; restart, game to 0x0005, gameOver → best_bcd stays 0x0012, new_best=0.
